// File: rtl/loop_stack_if.sv
// Bus between the fetch unit and the loop-address stack.
// The fetch unit takes the master modport and the stack takes the slave modport.
interface loop_stack_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256
);
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  flush;
    logic                  clear_err;
    logic [DATA_WIDTH-1:0] top_data;
    logic                  empty;
    logic                  full;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  high_water;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, push_data, flush, clear_err,
        input  top_data, empty, full, count, high_water, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, flush, clear_err,
        output top_data, empty, full, count, high_water, overflow, underflow
    );
endinterface

// File: rtl/loop_stack.sv
// Loop-address stack: the top entry is held in a register and the entries below it live in a synchronous RAM.
// The entry just below the top is prefetched, so pops on back-to-back cycles each show the correct top_data.
module loop_stack #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    loop_stack_if.slave   bus
);
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);
    localparam int unsigned RAM_DEPTH = DEPTH - 1;
    localparam int unsigned AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  hw_q, hw_d;
    logic [DATA_WIDTH-1:0] top_q, top_d;
    logic [DATA_WIDTH-1:0] below_q, below_d;
    logic                  below_ram_q, below_ram_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  ram_we, ram_re;
    logic [AW-1:0]         ram_waddr, ram_raddr;
    logic                  ovf_set, unf_set;
    logic [DATA_WIDTH-1:0] below_c;

    // After a pop the next-below entry sits in the RAM read register; after a push it is the old top.
    assign below_c = below_ram_q ? rd_q : below_q;

    always_comb begin
        count_d     = count_q;
        top_d       = top_q;
        below_d     = below_q;
        below_ram_d = below_ram_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_waddr   = '0;
        ram_raddr   = '0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;

        if (bus.flush) begin
            count_d = '0;
        end else if (bus.push && bus.pop && !empty_q) begin
            top_d = bus.push_data;
        end else if (bus.push) begin
            if (full_q) begin
                ovf_set = 1'b1;
            end else begin
                top_d   = bus.push_data;
                count_d = count_q + CNT_WIDTH'(1);
                if (!empty_q) begin
                    ram_we      = 1'b1;
                    ram_waddr   = AW'(count_q - CNT_WIDTH'(1));
                    below_d     = top_q;
                    below_ram_d = 1'b0;
                end
            end
        end else if (bus.pop) begin
            if (empty_q) begin
                unf_set = 1'b1;
            end else begin
                count_d = count_q - CNT_WIDTH'(1);
                top_d   = below_c;
                if (count_q >= CNT_WIDTH'(3)) begin
                    ram_re      = 1'b1;
                    ram_raddr   = AW'(count_q - CNT_WIDTH'(3));
                    below_ram_d = 1'b1;
                end
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_WIDTH'(DEPTH));
        hw_d    = (count_d > hw_q) ? count_d : hw_q;
        // An error event wins over clear_err in the same cycle.
        ovf_d   = (ovf_q & ~bus.clear_err) | ovf_set;
        unf_d   = (unf_q & ~bus.clear_err) | unf_set;
    end

    // A push never reads and a pop never writes, so a single port never sees a write and a read together.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= top_q;
        end
        if (ram_re) begin
            rd_q <= ram[ram_raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            hw_q        <= '0;
            top_q       <= '0;
            below_q     <= '0;
            below_ram_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            hw_q        <= hw_d;
            top_q       <= top_d;
            below_q     <= below_d;
            below_ram_q <= below_ram_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign bus.top_data   = top_q;
    assign bus.empty      = empty_q;
    assign bus.full       = full_q;
    assign bus.count      = count_q;
    assign bus.high_water = hw_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
endmodule

// File: doc/loop_stack.md
Name: loop_stack

Overview:
- Parameterised hardware loop-address stack for the brainfuck core.
- On `[` the fetch unit pushes the loop-start instruction address. On `]` it reads the top entry to branch back, or pops it on loop exit.
- Owns its own pointer, full/empty detection, sticky error flags and a high-water mark, so the controller no longer tracks a raw stack address.

Parameters:
- DATA_WIDTH, 16, width of one stored entry (instruction address width).
- DEPTH, 256, maximum number of entries; any integer >= 2, not restricted to powers of two.
- CNT_WIDTH, $clog2(DEPTH+1), width of the count and high-water outputs; derived, never overridden.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  push push_data this cycle.
- pop  in  1  discard top entry this cycle.
- push_data  in  DATA_WIDTH  value to push.
- flush  in  1  synchronous empty of the whole stack.
- clear_err  in  1  clears overflow and underflow.
- top_data  out  DATA_WIDTH  current top entry, registered.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  CNT_WIDTH  number of valid entries.
- high_water  out  CNT_WIDTH  maximum count reached since reset.
- overflow  out  1  sticky: a push was refused because the stack was full.
- underflow  out  1  sticky: a pop was refused because the stack was empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = 0, high_water = 0, top_data = 0.
  - overflow = 0, underflow = 0, empty = 1, full = 0.
  - Storage contents are don't-care. Reset mid-operation abandons any push or pop in flight.
- Latency: every operation takes effect at the clock edge. count, empty, full and top_data show the new state in the following cycle. Back-to-back operations are accepted every cycle, with no stall and no ready signal.
- Priority, evaluated per cycle: flush > push/pop.
- flush: count -> 0; top_data holds its value and is don't-care while empty. Errors are unaffected. Push and pop are ignored that cycle.
- push only, not full: new top = push_data; count +1.
- push only, full: no state change; overflow <= 1.
- pop only, count > 1: count -1; top_data = the entry pushed immediately before the removed one.
- pop only, count == 1: count -> 0; empty asserts.
- pop only, empty: no state change; underflow <= 1.
- push and pop together, not empty: replace top. top_data = push_data; count unchanged. This is legal when full and never sets overflow.
- push and pop together, empty: the push is performed (count -> 1). The pop is ignored and underflow is not set.
- Error flags:
  - overflow and underflow are sticky until clear_err.
  - If an error event and clear_err occur in the same cycle, the flag ends set.
- high_water: updates to the new count in the same edge that count exceeds it. flush does not reset it; only rst_n does.
- Storage:
  - top_data is a dedicated register; the remaining DEPTH-1 entries live in an inferred synchronous RAM.
  - Pops on consecutive cycles must each produce the correct top_data. The implementation holds a prefetched next-below entry and bypasses a RAM write-then-read to the same location.
  - No combinational path from any input to any output.
- Pointer arithmetic is exact for non-power-of-two DEPTH: there is no wrap-around, and full is detected on count == DEPTH.

Test Plan:
- Reset, then push 0x0010, 0x0020, 0x0030 on consecutive cycles -> count = 3, top_data = 0x0030, high_water = 3. Then pop on 3 consecutive cycles -> top_data = 0x0020, then 0x0010, then empty = 1 with count = 0. No error flags set.
- DEPTH = 5: push 6 times (values 1 to 6) -> full = 1 after the 5th push, overflow = 1 after the 6th, top_data = 5. Then pop 5 times -> the values read back 5, 4, 3, 2, 1.
- Empty stack, pop -> underflow = 1, count = 0. Pulse clear_err -> underflow = 0. Pop and clear_err in the same cycle -> underflow = 1.
- Push 0xAAAA, then push+pop with 0xBBBB -> count = 1, top_data = 0xBBBB. With the stack full, push+pop 0x1234 -> count stays at DEPTH, top = 0x1234, overflow = 0.
- Push 4 entries, then flush together with push -> count = 0, high_water = 4. A following push of 0x0042 -> count = 1, top_data = 0x0042.
- Assert rst_n low asynchronously between edges while count = 3 -> all outputs take their reset values immediately. The first push after release behaves normally.
